serial_link_credit_ctrl: RTL and testbench
==========================================

Name: serial_link_credit_ctrl

Overview:
- Credit-based flow-control stage between the network layer and the physical-layer channel of the serial link.
- TX side:
  - Gates outgoing data packets on credits granted by the peer.
  - Piggybacks locally freed receive credits onto each outgoing packet.
  - Emits credit-only packets when returns pile up.
- RX side:
  - Strips returned credits from incoming packets.
  - Forwards payload to the consumer.
  - Polices receive-buffer occupancy.

Parameters:
- DataWidth, 64, payload width of one packet.
- NumCredits, 8, outstanding packets per direction; equals the peer receive FIFO depth.
- ForceSendThresh, 4, pending-return count that triggers a credit-only packet; legal range 1..NumCredits.
- CW (derived), $clog2(NumCredits)+1, width of all credit fields and counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- data_in_i  in  DataWidth  payload from network layer
- data_in_valid_i  in  1  payload valid
- data_in_ready_o  out  1  payload accepted
- data_out_o  out  DataWidth  payload to PHY
- data_out_credit_o  out  CW  credits returned to peer
- data_out_credit_only_o  out  1  packet carries no payload
- data_out_valid_o  out  1  packet valid to PHY
- data_out_ready_i  in  1  PHY accepts packet
- rx_data_i  in  DataWidth  payload from PHY
- rx_credit_i  in  CW  credits returned by peer
- rx_credit_only_i  in  1  received packet has no payload
- rx_valid_i  in  1  received packet valid (no backpressure)
- rx_data_o  out  DataWidth  payload to consumer
- rx_valid_o  out  1  payload valid to consumer
- rx_consumed_i  in  1  consumer freed one receive-buffer slot
- credits_avail_o  out  CW  credits currently usable for TX
- credits_pending_o  out  CW  credits awaiting return to peer
- err_o  out  1  sticky protocol error

Behaviour:
- Reset values:
  - credits_avail = NumCredits; pending = 0; rx_occ = 0.
  - Output register empty: data_out_valid_o = 0; data_out_* = 0.
  - err_o = 0.
- Output register is a two-state FSM:
  - OutEmpty -> OutFull on load.
  - OutFull -> OutEmpty on handshake with no reload.
  - OutFull -> OutFull on handshake with reload in the same cycle.
- "Free" means OutEmpty, or OutFull with data_out_valid_o & data_out_ready_i this cycle.
- Load priority, evaluated only when free:
  - (1) data_in_valid_i && credits_avail > 0: load data packet, data_in_ready_o = 1, credit_only = 0.
  - (2) else pending >= ForceSendThresh: load credit-only packet, payload = 0.
  - (3) else no load.
- data_in_ready_o = free && credits_avail > 0; combinational, no dependency on data_in_valid_i.
- On load:
  - data_out_credit_o takes the registered pending value.
  - pending is reduced by that amount in the same cycle.
- Output stays stable while valid and not ready. Latency input to output: 1 cycle.
- pending_next = pending - loaded_credit + rx_consumed_i. A consume in the load cycle is kept for the next packet, never lost.
- credits_avail_next = credits_avail - data_load + (rx_valid_i ? rx_credit_i : 0).
  - Compute at CW+1 bits.
  - If the result exceeds NumCredits: set err_o and clamp to NumCredits.
- Credit-only packets never consume credits. Both sides at zero credits cannot deadlock, because the consumer's frees always reach ForceSendThresh.
- rx_valid_o = rx_valid_i & ~rx_credit_only_i; rx_data_o = rx_data_i. Both combinational pass-through.
- rx_occ_next = rx_occ + rx_valid_o - rx_consumed_i.
  - Payload arriving at rx_occ == NumCredits without a same-cycle consume: err_o set, count saturates.
  - rx_consumed_i at rx_occ == 0 without a same-cycle arrival: err_o set, count holds 0.
- err_o is sticky until rst_i.
- Reset mid-operation:
  - Any held output packet is dropped.
  - All counters return to reset values on the next edge, regardless of in-flight handshakes.

Test Plan:
- Burst of 10 data packets, data_out_ready_i = 1, no returns:
  - 8 accepted on consecutive cycles; data_in_ready_o = 0 after the 8th.
  - credits_avail_o = 0; data_out_credit_o = 0 throughout.
- From zero credits, rx packet with rx_credit_i = 3, rx_credit_only_i = 1:
  - rx_valid_o stays 0; credits_avail_o = 3 next cycle.
  - Exactly 3 more data packets leave.
- 4 rx payloads, then 4 rx_consumed_i pulses, TX idle, ForceSendThresh = 4:
  - One credit-only packet with data_out_credit_o = 4; credits_pending_o = 0 after load.
- data_out_ready_i held 0 for 5 cycles with a packet loaded, consumer pulsing each cycle:
  - data_out_o and data_out_credit_o unchanged.
  - credits_pending_o counts 1..5; next packet carries 5.
- Load and rx_consumed_i in the same cycle, pending = 2:
  - Packet carries 2; credits_pending_o = 1 afterward.
- rx_credit_i = 2 while credits_avail = 7:
  - err_o = 1 next cycle; credits_avail_o = 8.
- 9th payload with rx_occ = 8:
  - err_o = 1.
- rst_i pulse:
  - err_o = 0; credits_avail_o = 8.

Source files
------------

// File: rtl/serial_link_credit_ctrl.sv
// Credit-based flow control between the network layer and the serial-link PHY:
// credit-gated TX with piggybacked credit returns, and an RX side that polices buffer occupancy.
module serial_link_credit_ctrl #(
  parameter int DataWidth       = 64,
  parameter int NumCredits      = 8,
  parameter int ForceSendThresh = 4,
  localparam int CW             = $clog2(NumCredits) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DataWidth-1:0] data_in_i,
  input  logic                 data_in_valid_i,
  output logic                 data_in_ready_o,
  output logic [DataWidth-1:0] data_out_o,
  output logic [CW-1:0]        data_out_credit_o,
  output logic                 data_out_credit_only_o,
  output logic                 data_out_valid_o,
  input  logic                 data_out_ready_i,
  input  logic [DataWidth-1:0] rx_data_i,
  input  logic [CW-1:0]        rx_credit_i,
  input  logic                 rx_credit_only_i,
  input  logic                 rx_valid_i,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_consumed_i,
  output logic [CW-1:0]        credits_avail_o,
  output logic [CW-1:0]        credits_pending_o,
  output logic                 err_o
);

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  localparam logic [CW:0]   MaxCredits = (CW+1)'(NumCredits);
  localparam logic [CW-1:0] MaxOcc     = CW'(NumCredits);
  localparam logic [CW-1:0] Thresh     = CW'(ForceSendThresh);

  out_state_t           state_q, state_d;
  logic [DataWidth-1:0] out_data_q;
  logic [CW-1:0]        out_credit_q;
  logic                 out_credit_only_q;
  logic [CW-1:0]        avail_q, avail_d;
  logic [CW-1:0]        pending_q, pending_d;
  logic [CW-1:0]        occ_q, occ_d;
  logic                 err_q, err_d;

  logic        free, has_credit, load_data, load_credit, load, arrive;
  logic [CW:0] avail_sum, pending_sum;
  logic [CW-1:0] pending_base;

  assign has_credit = (avail_q != '0);
  assign arrive     = rx_valid_i & ~rx_credit_only_i;

  always_comb begin
    state_d     = state_q;
    free        = 1'b0;
    load_data   = 1'b0;
    load_credit = 1'b0;
    unique case (state_q)
      OUT_EMPTY: free = 1'b1;
      OUT_FULL:  free = data_out_ready_i;
      default:   free = 1'b0;
    endcase
    if (free) begin
      if (data_in_valid_i && has_credit) begin
        load_data = 1'b1;
      end else if (pending_q >= Thresh) begin
        load_credit = 1'b1;
      end
    end
    load = load_data | load_credit;
    if (load) begin
      state_d = OUT_FULL;
    end else if (free) begin
      state_d = OUT_EMPTY;
    end
  end

  // A load hands over all pending credits; a consume in the same cycle lands in the new count.
  always_comb begin
    err_d        = err_q;
    pending_base = load ? '0 : pending_q;
    pending_sum  = {1'b0, pending_base} + {{CW{1'b0}}, rx_consumed_i};
    pending_d    = pending_sum[CW] ? '1 : pending_sum[CW-1:0];

    avail_sum = {1'b0, avail_q} - {{CW{1'b0}}, load_data}
              + (rx_valid_i ? {1'b0, rx_credit_i} : '0);
    if (avail_sum > MaxCredits) begin
      avail_d = MaxOcc;
      err_d   = 1'b1;
    end else begin
      avail_d = avail_sum[CW-1:0];
    end

    occ_d = occ_q;
    if (arrive && !rx_consumed_i) begin
      if (occ_q == MaxOcc) err_d = 1'b1;
      else                 occ_d = occ_q + 1'b1;
    end else if (rx_consumed_i && !arrive) begin
      if (occ_q == '0) err_d = 1'b1;
      else             occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= OUT_EMPTY;
      out_data_q        <= '0;
      out_credit_q      <= '0;
      out_credit_only_q <= 1'b0;
      avail_q           <= MaxOcc;
      pending_q         <= '0;
      occ_q             <= '0;
      err_q             <= 1'b0;
    end else begin
      state_q   <= state_d;
      avail_q   <= avail_d;
      pending_q <= pending_d;
      occ_q     <= occ_d;
      err_q     <= err_d;
      if (load) begin
        out_data_q        <= load_data ? data_in_i : '0;
        out_credit_q      <= pending_q;
        out_credit_only_q <= load_credit;
      end else if (free) begin
        out_data_q        <= '0;
        out_credit_q      <= '0;
        out_credit_only_q <= 1'b0;
      end
    end
  end

  assign data_in_ready_o        = free & has_credit;
  assign data_out_o             = out_data_q;
  assign data_out_credit_o      = out_credit_q;
  assign data_out_credit_only_o = out_credit_only_q;
  assign data_out_valid_o       = (state_q == OUT_FULL);
  assign rx_data_o              = rx_data_i;
  assign rx_valid_o             = arrive;
  assign credits_avail_o        = avail_q;
  assign credits_pending_o      = pending_q;
  assign err_o                  = err_q;

endmodule

// File: tb/tb_serial_link_credit_ctrl.sv
// Scoreboard bench: a credit/occupancy model queues expected TX packets; a monitor checks each PHY handshake.
module tb_serial_link_credit_ctrl;
  localparam int N  = 8;
  localparam int TH = 4;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [63:0]   data_in_i;
  logic          data_in_valid_i;
  logic          data_in_ready_o;
  logic [63:0]   data_out_o;
  logic [CW-1:0] data_out_credit_o;
  logic          data_out_credit_only_o;
  logic          data_out_valid_o;
  logic          data_out_ready_i;
  logic [63:0]   rx_data_i;
  logic [CW-1:0] rx_credit_i;
  logic          rx_credit_only_i;
  logic          rx_valid_i;
  logic [63:0]   rx_data_o;
  logic          rx_valid_o;
  logic          rx_consumed_i;
  logic [CW-1:0] credits_avail_o;
  logic [CW-1:0] credits_pending_o;
  logic          err_o;

  serial_link_credit_ctrl #(.DataWidth(64), .NumCredits(N), .ForceSendThresh(TH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .data_in_i(data_in_i), .data_in_valid_i(data_in_valid_i), .data_in_ready_o(data_in_ready_o),
    .data_out_o(data_out_o), .data_out_credit_o(data_out_credit_o),
    .data_out_credit_only_o(data_out_credit_only_o), .data_out_valid_o(data_out_valid_o),
    .data_out_ready_i(data_out_ready_i),
    .rx_data_i(rx_data_i), .rx_credit_i(rx_credit_i), .rx_credit_only_i(rx_credit_only_i),
    .rx_valid_i(rx_valid_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_consumed_i(rx_consumed_i), .credits_avail_o(credits_avail_o),
    .credits_pending_o(credits_pending_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] data;
    int          credit;
    bit          credit_only;
  } pkt_t;

  pkt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_avail, m_pend, m_occ;
  bit m_err, m_full;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshake monitor: the packet presented during an accepted cycle must be the oldest queued one.
  always @(negedge clk_i) begin
    if (!rst_i && data_out_valid_o && data_out_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_packet", 64'd1, 64'd0);
      end else begin
        pkt_t p;
        p = exp_q.pop_front();
        chk("pkt_data", data_out_o, p.data);
        chk("pkt_credit", 64'(data_out_credit_o), 64'(p.credit));
        chk("pkt_credit_only", 64'(data_out_credit_only_o), 64'(p.credit_only));
      end
    end
  end

  task automatic step();
    bit arrive, free, exp_rdy, ld_d, ld_c;
    int na;
    #1;
    if (rst_i) begin
      m_avail = N; m_pend = 0; m_occ = 0; m_err = 0; m_full = 0;
      exp_q.delete();
    end else begin
      arrive  = rx_valid_i && !rx_credit_only_i;
      free    = !m_full || data_out_ready_i;
      exp_rdy = free && (m_avail > 0);
      chk("in_ready", 64'(data_in_ready_o), 64'(exp_rdy));
      chk("rx_valid", 64'(rx_valid_o), 64'(arrive));
      if (arrive) chk("rx_data", rx_data_o, rx_data_i);
      ld_d = exp_rdy && data_in_valid_i;
      ld_c = free && !ld_d && (m_pend >= TH);
      if (ld_d) exp_q.push_back('{data: data_in_i, credit: m_pend, credit_only: 1'b0});
      if (ld_c) exp_q.push_back('{data: 64'd0, credit: m_pend, credit_only: 1'b1});
      if (ld_d || ld_c) m_pend = 0;
      m_pend += int'(rx_consumed_i);
      na = m_avail - int'(ld_d) + (rx_valid_i ? int'(rx_credit_i) : 0);
      if (na > N) begin m_err = 1; na = N; end
      m_avail = na;
      if (arrive && !rx_consumed_i) begin
        if (m_occ == N) m_err = 1; else m_occ++;
      end else if (rx_consumed_i && !arrive) begin
        if (m_occ == 0) m_err = 1; else m_occ--;
      end
      m_full = ld_d || ld_c || (m_full && !data_out_ready_i);
    end
    @(posedge clk_i); #1;
    chk("credits_avail", 64'(credits_avail_o), 64'(m_avail));
    chk("credits_pending", 64'(credits_pending_o), 64'(m_pend));
    chk("err", 64'(err_o), 64'(m_err));
    chk("out_valid", 64'(data_out_valid_o), 64'(m_full));
  endtask

  task automatic drive(input bit iv, input bit rdy, input bit rv, input int rc,
                       input bit rco, input bit cons);
    data_in_i        = {$urandom, $urandom};
    data_in_valid_i  = iv;
    data_out_ready_i = rdy;
    rx_data_i        = {$urandom, $urandom};
    rx_valid_i       = rv;
    rx_credit_i      = CW'(rc);
    rx_credit_only_i = rco;
    rx_consumed_i    = cons;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    data_in_i = '0; data_in_valid_i = 0; data_out_ready_i = 0;
    rx_data_i = '0; rx_credit_i = '0; rx_credit_only_i = 0; rx_valid_i = 0; rx_consumed_i = 0;
    do_reset();
    do_reset();
    chk("reset_out_data", data_out_o, 64'd0);

    // Burst of 10 with no credit returns: only 8 go out.
    for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0, 0);
    idle(2);
    // Credit-only return of 3, then 5 offered packets of which 3 leave.
    drive(0, 1, 1, 3, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 0);
    idle(2);
    // 4 payloads in, 4 consumes, TX idle -> one credit-only packet carrying 4.
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 1);
    idle(3);
    // Output stall while consumer frees 5 slots.
    drive(0, 1, 1, 8, 1, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0);
    idle(2);
    // Load coinciding with a consume at pending = 2.
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 1);
    idle(2);

    // Randomized legal traffic.
    for (int i = 0; i < 400; i++) begin
      bit iv, rdy, rv, rco, cons;
      int rc;
      iv   = $urandom_range(0, 1) == 1;
      rdy  = $urandom_range(0, 3) != 0;
      rv   = $urandom_range(0, 2) == 0;
      rco  = $urandom_range(0, 1) == 1;
      rc   = (m_avail < N) ? int'($urandom_range(0, N - m_avail)) : 0;
      if (m_occ >= N) rco = 1;
      cons = (m_occ > 0) && (m_pend < 12) && ($urandom_range(0, 2) == 0);
      drive(iv, rdy, rv, rc, rco, cons);
    end
    idle(4);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Credit overflow: avail 7 plus a return of 2.
    do_reset();
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 2, 1, 0);
    idle(1);
    do_reset();
    // Ninth payload into a full receive buffer.
    for (int i = 0; i < 9; i++) drive(0, 1, 1, 0, 0, 0);
    do_reset();
    // Consume from an empty receive buffer.
    drive(0, 1, 0, 0, 0, 1);
    do_reset();
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
